// File: rtl/background_collision_detector.sv
// Probes the eight level tiles bordering the player sprite and reports which sides touch solid tiles.
// One probe address per clock, ROM result folded in two edges later, flags committed together at E10.
module background_collision_detector #(
    parameter int         TILE_SHIFT = 3,
    parameter int         TILE_ROWS  = 15,
    parameter int         COL_BITS   = 11,
    parameter logic [3:0] EMPTY_CODE = 4'd0
) (
    input  logic                  CLOCK_50,
    input  logic                  resetn,
    input  logic                  enable,
    input  logic [31:0]           x_position,
    input  logic [6:0]            y_position,
    input  logic [4:0]            width,
    input  logic [4:0]            height,
    output logic [COL_BITS+3:0]   level_address,
    input  logic [3:0]            tile_code,
    output logic                  blocked_down,
    output logic                  blocked_up,
    output logic                  blocked_left,
    output logic                  blocked_right,
    output logic                  out_of_bounds,
    output logic                  done
);

    typedef enum logic [1:0] {IDLE, PROBE, DRAIN, DONE} state_t;

    // side: 0 down, 1 right, 2 left, 3 up
    typedef struct packed {
        logic [1:0] side;
        logic       solid;
        logic       empty;
        logic       oob;
    } meta_t;

    state_t               state_q, state_d;
    logic [3:0]           cnt_q;
    logic [31:0]          x_q;
    logic [6:0]           y_q;
    logic [4:0]           w_q, h_q;
    logic [COL_BITS+3:0]  addr_q;
    meta_t                meta1_q, meta2_q;
    logic [3:0]           shadow_q, flags_q;
    logic                 sh_oob_q, oob_q, done_q;

    logic [31:0]          src_x;
    logic [6:0]           src_y;
    logic [4:0]           src_w, src_h;
    logic [2:0]           pk;
    logic [32:0]          x_ext, x_r, x_rm1, x_l, px, px_sh;
    logic [7:0]           y_ext, y_b, y_bm1, y_t, py, py_sh;
    logic                 x_borrow, y_borrow, col_off, row_off;
    logic [COL_BITS-1:0]  probe_col;
    logic [3:0]           probe_row;
    meta_t                probe_meta;
    logic                 hit, consume;

    // Probe 0 is issued on the same edge that latches the inputs, so it reads them live.
    always_comb begin
        if (state_q == IDLE) begin
            src_x = x_position;
            src_y = y_position;
            src_w = (width  == '0) ? 5'd1 : width;
            src_h = (height == '0) ? 5'd1 : height;
            pk    = '0;
        end else begin
            src_x = x_q;
            src_y = y_q;
            src_w = w_q;
            src_h = h_q;
            pk    = cnt_q[2:0];
        end

        x_ext = {1'b0, src_x};
        x_r   = x_ext + 33'(src_w);
        x_rm1 = x_r - 33'd1;
        x_l   = x_ext - 33'd1;
        y_ext = {1'b0, src_y};
        y_b   = y_ext + 8'(src_h);
        y_bm1 = y_b - 8'd1;
        y_t   = y_ext - 8'd1;

        case (pk)
            3'd0:    begin px = x_ext; py = y_b;   end
            3'd1:    begin px = x_rm1; py = y_b;   end
            3'd2:    begin px = x_r;   py = y_ext; end
            3'd3:    begin px = x_r;   py = y_bm1; end
            3'd4:    begin px = x_l;   py = y_ext; end
            3'd5:    begin px = x_l;   py = y_bm1; end
            3'd6:    begin px = x_ext; py = y_t;   end
            default: begin px = x_rm1; py = y_t;   end
        endcase

        px_sh    = px >> TILE_SHIFT;
        py_sh    = py >> TILE_SHIFT;
        x_borrow = (pk[2:1] == 2'b10) && (src_x == '0);
        y_borrow = (pk[2:1] == 2'b11) && (src_y == '0);
        col_off  = |(px_sh >> COL_BITS);
        row_off  = !y_borrow && (py_sh >= 8'(TILE_ROWS));

        // Off-map probes still emit an in-range address; the borrow case clamps low, never wraps.
        probe_col = x_borrow ? '0 : (col_off ? '1 : px_sh[COL_BITS-1:0]);
        probe_row = y_borrow ? '0 : (row_off ? 4'(TILE_ROWS - 1) : py_sh[3:0]);

        probe_meta.side  = pk[2:1];
        probe_meta.empty = row_off;
        probe_meta.solid = (x_borrow | y_borrow | col_off) & ~row_off;
        probe_meta.oob   = row_off && (pk[2:1] == 2'b00);
    end

    assign hit     = meta2_q.solid | (~meta2_q.empty & (tile_code != EMPTY_CODE));
    assign consume = (cnt_q >= 4'd2) && (cnt_q <= 4'd9);

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:  if (enable) state_d = PROBE;
            PROBE: if (!enable) state_d = IDLE; else if (cnt_q == 4'd7) state_d = DRAIN;
            DRAIN: if (!enable) state_d = IDLE; else if (cnt_q == 4'd10) state_d = DONE;
            DONE:  if (!enable) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            x_q      <= '0;
            y_q      <= '0;
            w_q      <= '0;
            h_q      <= '0;
            addr_q   <= '0;
            meta1_q  <= '0;
            meta2_q  <= '0;
            shadow_q <= '0;
            flags_q  <= '0;
            sh_oob_q <= 1'b0;
            oob_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            case (state_q)
                IDLE: begin
                    if (enable) begin
                        x_q      <= src_x;
                        y_q      <= src_y;
                        w_q      <= src_w;
                        h_q      <= src_h;
                        cnt_q    <= 4'd1;
                        addr_q   <= {probe_col, probe_row};
                        meta1_q  <= probe_meta;
                        meta2_q  <= '0;
                        shadow_q <= '0;
                        sh_oob_q <= 1'b0;
                    end else begin
                        addr_q <= '0;
                    end
                end
                PROBE, DRAIN: begin
                    if (!enable) begin
                        addr_q <= '0;
                    end else begin
                        cnt_q   <= cnt_q + 4'd1;
                        meta1_q <= probe_meta;
                        meta2_q <= meta1_q;
                        addr_q  <= (state_q == PROBE) ? {probe_col, probe_row} : '0;
                        if (consume) begin
                            shadow_q[meta2_q.side] <= shadow_q[meta2_q.side] | hit;
                            sh_oob_q               <= sh_oob_q | meta2_q.oob;
                        end
                        if (state_q == DRAIN && cnt_q == 4'd10) begin
                            flags_q <= shadow_q;
                            oob_q   <= sh_oob_q;
                            done_q  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    addr_q <= '0;
                    if (!enable) done_q <= 1'b0;
                end
                default: addr_q <= '0;
            endcase
        end
    end

    assign level_address = addr_q;
    assign blocked_down  = flags_q[0];
    assign blocked_right = flags_q[1];
    assign blocked_left  = flags_q[2];
    assign blocked_up    = flags_q[3];
    assign out_of_bounds = oob_q;
    assign done          = done_q;

endmodule

// File: tb/tb_background_collision_detector.sv
// Bench for background_collision_detector: registered tile ROM model, address/flag scoreboard.
module tb_background_collision_detector;

    logic        CLOCK_50 = 1'b0;
    logic        resetn;
    logic        enable;
    logic [31:0] x_position;
    logic [6:0]  y_position;
    logic [4:0]  width, height;
    logic [14:0] level_address;
    logic [3:0]  tile_code = 4'd0;
    logic        blocked_down, blocked_up, blocked_left, blocked_right, out_of_bounds, done;
    logic [4:0]  flags_o;

    int          map_sel = 0;
    int          n_checks = 0;
    int          n_errors = 0;
    logic [14:0] exp_addr_q[$];
    logic [4:0]  exp_flag_q[$];
    logic [4:0]  last_flags = '0;

    background_collision_detector #(
        .TILE_SHIFT(3),
        .TILE_ROWS (15),
        .COL_BITS  (11),
        .EMPTY_CODE(4'd0)
    ) dut (
        .CLOCK_50     (CLOCK_50),
        .resetn       (resetn),
        .enable       (enable),
        .x_position   (x_position),
        .y_position   (y_position),
        .width        (width),
        .height       (height),
        .level_address(level_address),
        .tile_code    (tile_code),
        .blocked_down (blocked_down),
        .blocked_up   (blocked_up),
        .blocked_left (blocked_left),
        .blocked_right(blocked_right),
        .out_of_bounds(out_of_bounds),
        .done         (done)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    // {oob, down, up, left, right}
    assign flags_o = {out_of_bounds, blocked_down, blocked_up, blocked_left, blocked_right};

    function automatic logic [3:0] tile_at(input int sel, input int col, input int row);
        case (sel)
            1:       return (row == 8 && col >= 2 && col <= 3) ? 4'd1 : 4'd0;
            2:       return (col == 3) ? 4'd9 : 4'd0;
            default: return 4'd0;
        endcase
    endfunction

    always @(posedge CLOCK_50)
        tile_code <= tile_at(map_sel, int'(level_address[14:4]), int'(level_address[3:0]));

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic push_expected(input longint x, input longint y, input longint w, input longint h);
        longint we, he, px, py, col, row;
        int ca, ra;
        bit solid, empty;
        logic [4:0] fl;
        fl = '0;
        we = (w == 0) ? 1 : w;
        he = (h == 0) ? 1 : h;
        for (int k = 0; k < 8; k++) begin
            case (k)
                0:       begin px = x;          py = y + he;     end
                1:       begin px = x + we - 1; py = y + he;     end
                2:       begin px = x + we;     py = y;          end
                3:       begin px = x + we;     py = y + he - 1; end
                4:       begin px = x - 1;      py = y;          end
                5:       begin px = x - 1;      py = y + he - 1; end
                6:       begin px = x;          py = y - 1;      end
                default: begin px = x + we - 1; py = y - 1;      end
            endcase
            solid = 1'b0;
            empty = 1'b0;
            if (px < 0) begin
                ca = 0; solid = 1'b1;
            end else begin
                col = px / 8;
                if (col >= 2048) begin ca = 2047; solid = 1'b1; end
                else ca = int'(col);
            end
            if (py < 0) begin
                ra = 0; solid = 1'b1;
            end else begin
                row = py / 8;
                if (row >= 15) begin
                    ra = 14; empty = 1'b1;
                    if (k < 2) fl[4] = 1'b1;
                end else ra = int'(row);
            end
            exp_addr_q.push_back(15'(ca * 16 + ra));
            if (!empty && (solid || tile_at(map_sel, ca, ra) != 4'd0)) begin
                case (k / 2)
                    0:       fl[3] = 1'b1;
                    1:       fl[0] = 1'b1;
                    2:       fl[1] = 1'b1;
                    default: fl[2] = 1'b1;
                endcase
            end
        end
        exp_flag_q.push_back(fl);
    endtask

    task automatic run_check(input int sel, input logic [31:0] x, input logic [6:0] y,
                             input logic [4:0] w, input logic [4:0] h);
        int edge_n;
        @(negedge CLOCK_50);
        map_sel = sel;
        x_position = x; y_position = y; width = w; height = h;
        enable = 1'b1;
        push_expected(longint'(x), longint'(y), longint'(w), longint'(h));
        @(posedge CLOCK_50);
        for (int k = 0; k < 8; k++) begin
            @(negedge CLOCK_50);
            check("addr", level_address, exp_addr_q.pop_front());
            check("done_early", done, 0);
            if (k == 0) begin
                x_position = $urandom;
                y_position = 7'($urandom);
                width      = 5'($urandom);
                height     = 5'($urandom);
            end
        end
        edge_n = 7;
        while (!done && edge_n < 30) begin
            @(posedge CLOCK_50);
            @(negedge CLOCK_50);
            edge_n++;
        end
        check("latency", edge_n, 10);
        last_flags = exp_flag_q.pop_front();
        check("flags", flags_o, last_flags);
        check("done", done, 1);
    endtask

    task automatic release_enable();
        @(negedge CLOCK_50);
        enable = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("done_clear", done, 0);
        check("addr_idle", level_address, 0);
        check("flags_held", flags_o, last_flags);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        resetn = 1'b0; enable = 1'b0;
        x_position = '0; y_position = '0; width = '0; height = '0;
        repeat (3) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("rst_flags", flags_o, 0);
        check("rst_done", done, 0);
        check("rst_addr", level_address, 0);
        resetn = 1'b1;

        run_check(0, 32'd16, 7'd56, 5'd8, 5'd8);        // empty level
        release_enable();
        run_check(1, 32'd16, 7'd56, 5'd8, 5'd8);        // floor
        release_enable();
        run_check(2, 32'd16, 7'd56, 5'd8, 5'd8);        // right wall, then hold enable
        for (int i = 0; i < 6; i++) begin
            @(negedge CLOCK_50);
            check("hold_done", done, 1);
            check("hold_addr", level_address, 0);
        end
        release_enable();
        run_check(0, 32'd0, 7'd0, 5'd8, 5'd8);          // left and top map edges
        release_enable();
        run_check(0, 32'd16376, 7'd112, 5'd8, 5'd8);    // pit and right map edge
        release_enable();

        // Abort at E5
        @(negedge CLOCK_50);
        map_sel = 1;
        x_position = 32'd16; y_position = 7'd56; width = 5'd8; height = 5'd8;
        enable = 1'b1;
        @(posedge CLOCK_50);
        repeat (4) @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        enable = 1'b0;
        @(posedge CLOCK_50);
        @(negedge CLOCK_50);
        check("abort_addr", level_address, 0);
        for (int i = 0; i < 8; i++) begin
            @(negedge CLOCK_50);
            check("abort_done", done, 0);
        end
        check("abort_flags", flags_o, last_flags);

        run_check(1, 32'd16, 7'd56, 5'd8, 5'd8);        // re-raise after abort
        release_enable();

        // Asynchronous reset at E4
        @(negedge CLOCK_50);
        map_sel = 0;
        x_position = 32'd16; y_position = 7'd56; width = 5'd8; height = 5'd8;
        enable = 1'b1;
        @(posedge CLOCK_50);
        repeat (4) @(posedge CLOCK_50);
        #1 resetn = 1'b0;
        #1;
        check("midrst_flags", flags_o, 0);
        check("midrst_done", done, 0);
        check("midrst_addr", level_address, 0);
        enable = 1'b0;
        last_flags = '0;
        @(negedge CLOCK_50);
        @(negedge CLOCK_50);
        resetn = 1'b1;

        run_check(0, 32'd20, 7'd39, 5'd0, 5'd0);        // zero size treated as 1x1
        release_enable();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
